divi_seq: RTL and testbench
===========================

// Module: divi_seq
// PURPOSE
//  Iterative unsigned restoring divider: the inverse operation of the combinational
//  4-bit multiplier on the FPGA controller datapath. Computes a / b one quotient bit
//  per clock, with a start/busy/done handshake toward the controller FSM.
//  Results (quotient, remainder, divide-by-zero flag) are held until the next accepted start.
// PARAMETERS
//  WIDTH  4  operand, quotient and remainder width in bits (>= 2)
// PORTS
//  clk       in   1      single system clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  start     in   1      request; sampled only in IDLE
//  a         in   WIDTH  dividend, captured at the accepting edge
//  b         in   WIDTH  divisor, captured at the accepting edge
//  busy      out  1      high while state != IDLE
//  done      out  1      one-cycle pulse: results valid from this cycle on
//  q         out  WIDTH  quotient
//  r         out  WIDTH  remainder
//  div_zero  out  1      b was 0 for the current result
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy=0, done=0, q=0, r=0, div_zero=0; internal
//    registers and iteration counter cleared. Reset mid-RUN aborts; no done is produced.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE: start=0 -> stay. start=1 at edge k: latch a, b.
//      b==0: q=all ones, r=a, div_zero=1, go DONE (done high after edge k).
//      b!=0: div_zero=0, rem=0, dvd=a, cnt=WIDTH-1, go RUN.
//  - RUN, one iteration per edge:
//      t = {rem, dvd[MSB]} (WIDTH+1 bits); dvd <<= 1;
//      t >= {1'b0,b}: rem = t-b, quotient LSB shifted in = 1; else rem = t[WIDTH-1:0], bit = 0.
//      cnt==0 at the edge -> go DONE, q/r updated with the final values.
//    Edges k+1..k+WIDTH perform the WIDTH iterations; done is high during the cycle
//    after edge k+WIDTH. Latency start->done = WIDTH+1 edges (1 edge for b==0).
//  - DONE: done=1 for exactly one cycle, busy=1. Unconditionally go IDLE; start is ignored.
//  - start while busy (RUN or DONE) is ignored and does not change a/b captures.
//  - q, r and div_zero change only at the edge that enters DONE. While RUN they keep the
//    previous result; q/r are driven from separate result registers, not the working registers.
//  - Arithmetic is unsigned. All comparisons use WIDTH+1 bits; no overflow is possible.
//    Back-to-back: start held high re-accepts in the first IDLE cycle after DONE.
// STRUCTURE
//  - div_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t.
//  - div_step: combinational sub-module, one restoring iteration:
//    (rem, msb, b) -> (rem_next, qbit).
//  - divi_seq: FSM, counter ($clog2(WIDTH) bits), working and result registers.
// TESTING (WIDTH=4)
//  - a=13,b=3, start pulse -> busy=1 next cycle; done after 5 edges; q=4, r=1, div_zero=0.
//  - a=15,b=15 -> q=1,r=0.
//    a=7,b=9 -> q=0,r=7.
//    a=15,b=1 -> q=15,r=0.
//  - a=8,b=0 -> done after 1 edge; q=15, r=8, div_zero=1; next a=6,b=2 clears div_zero, q=3.
//  - Start pulsed again with a=2,b=1 during RUN of 13/3 -> ignored; result stays q=4, r=1;
//    q/r keep the prior result until done.
//  - rst asserted mid-RUN (2nd iteration) -> outputs 0 immediately, no done pulse;
//    after release, 9/2 -> q=4, r=1.
//  - start held high continuously -> one done every 6 cycles; done width is exactly 1 cycle.
//  - Exhaustive sweep of all 256 (a,b) pairs against a/b and a%b (b!=0) plus the b==0 rule.

Source files
------------

// File: rtl/divi_seq_pkg.sv
// -----------------------------------------------------------------------------
// divi_seq_pkg
// Shared types and helpers for the iterative restoring divider.
//   div_state_t : controller FSM states (IDLE, RUN, DONE)
//   cnt_width() : width of the iteration counter for a given operand width
// -----------------------------------------------------------------------------
package divi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // The counter runs WIDTH-1 down to 0, so $clog2(WIDTH) bits are enough.
  // The guard keeps the width legal for degenerate parameter values.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/divi_seq_if.sv
// -----------------------------------------------------------------------------
// divi_seq_if
// Handshake and data bundle between the controller and the divider.
//   start    : request (controller -> divider)
//   a, b     : dividend / divisor (controller -> divider)
//   busy     : divider not idle
//   done     : one-cycle pulse, results valid from this cycle on
//   q, r     : quotient / remainder
//   div_zero : current result came from a zero divisor
// Modports: master = controller side, slave = divider side.
// -----------------------------------------------------------------------------
interface divi_seq_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_zero;

  modport master (
    output start, a, b,
    input  busy, done, q, r, div_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, div_zero
  );

endinterface

// File: rtl/divi_seq_step.sv
// -----------------------------------------------------------------------------
// divi_seq_step
// One combinational restoring-division iteration.
//   rem_i      : partial remainder before the step
//   msb_i      : next dividend bit shifted into the remainder
//   b_i        : divisor
//   rem_next_o : partial remainder after the step
//   qbit_o     : quotient bit produced by this step
// -----------------------------------------------------------------------------
module divi_seq_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] rem_next_o,
  output logic             qbit_o
);

  logic [WIDTH:0] trial;

  assign trial = {rem_i, msb_i};

  always_comb begin
    qbit_o     = 1'b0;
    rem_next_o = trial[WIDTH-1:0];
    if (trial >= {1'b0, b_i}) begin
      qbit_o = 1'b1;
      // trial - b < b, so the difference always fits in WIDTH bits and the
      // subtraction can be done modulo 2**WIDTH on the low bits alone.
      rem_next_o = trial[WIDTH-1:0] - b_i;
    end
  end

endmodule

// File: rtl/divi_seq.sv
// -----------------------------------------------------------------------------
// divi_seq
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : divi_seq_if slave modport (start/a/b in, busy/done/q/r/div_zero out)
// A zero divisor completes in one edge with q = all ones, r = a, div_zero = 1.
// Otherwise WIDTH iterations follow the accepting edge, then one DONE cycle.
// Results live in dedicated registers and only change on entry to DONE.
// -----------------------------------------------------------------------------
module divi_seq
  import divi_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  divi_seq_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             div_zero_q;

  // Working registers: dvd_q shifts the dividend out at the top while the
  // quotient bits shift in at the bottom.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] rem_d;
  logic             qbit_d;
  logic [WIDTH-1:0] dvd_d;

  divi_seq_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i      (rem_q),
    .msb_i      (dvd_q[WIDTH-1]),
    .b_i        (b_q),
    .rem_next_o (rem_d),
    .qbit_o     (qbit_d)
  );

  assign dvd_d = {dvd_q[WIDTH-2:0], qbit_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      div_zero_q <= 1'b0;
      rem_q      <= '0;
      dvd_q      <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            b_q    <= bus.b;
            busy_q <= 1'b1;
            if (bus.b == '0) begin
              q_q        <= '1;
              r_q        <= bus.a;
              div_zero_q <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              rem_q   <= '0;
              dvd_q   <= bus.a;
              cnt_q   <= CNT_W'(WIDTH - 1);
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          if (cnt_q == '0) begin
            q_q        <= dvd_d;
            r_q        <= rem_d;
            div_zero_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.q        = q_q;
  assign bus.r        = r_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_divi_seq.sv
module tb_divi_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  divi_seq_if #(.WIDTH(4)) bus_if ();

  divi_seq #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one request and wait (bounded) for done; lat counts negedges from
  // the request until done is seen, 20 means it never arrived.
  task automatic launch(input logic [3:0] av, input logic [3:0] bv, output int lat);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = av;
    bus_if.b     = bv;
    lat = 0;
    repeat (20) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      lat++;
      if (bus_if.done) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a = 4'd0;
    bus_if.b = 4'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus_if.busy, bus_if.done, bus_if.q, bus_if.r, bus_if.div_zero} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b q=%0d r=%0d dz=%0b, want all 0",
               bus_if.busy, bus_if.done, bus_if.q, bus_if.r, bus_if.div_zero);
    end
    rst = 1'b0;
    $display("reset: busy=%0b done=%0b q=%0d r=%0d dz=%0b",
             bus_if.busy, bus_if.done, bus_if.q, bus_if.r, bus_if.div_zero);
  endtask

  task automatic test_basic();
    int lat;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.a = 4'd13; bus_if.b = 4'd3;
    @(negedge clk);
    bus_if.start = 1'b0;
    n_cmp++;
    if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: got busy=%0b done=%0b, want busy=1 done=0", bus_if.busy, bus_if.done);
    end
    lat = 1;
    while (!bus_if.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges, want 5", lat);
    end
    n_cmp++;
    if (bus_if.q !== 4'd4 || bus_if.r !== 4'd1 || bus_if.div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_13_3: got q=%0d r=%0d dz=%0b, want q=4 r=1 dz=0", bus_if.q, bus_if.r, bus_if.div_zero);
    end
    $display("basic 13/3: lat=%0d q=%0d r=%0d dz=%0b", lat, bus_if.q, bus_if.r, bus_if.div_zero);
  endtask

  task automatic test_vectors();
    logic [3:0] va [3] = '{4'd15, 4'd7, 4'd15};
    logic [3:0] vb [3] = '{4'd15, 4'd9, 4'd1};
    logic [3:0] vq [3] = '{4'd1,  4'd0, 4'd15};
    logic [3:0] vr [3] = '{4'd0,  4'd7, 4'd0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], lat);
      n_cmp++;
      if (lat !== 5 || bus_if.q !== vq[i] || bus_if.r !== vr[i] || bus_if.div_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL vector_%0d_%0d: got lat=%0d q=%0d r=%0d dz=%0b, want lat=5 q=%0d r=%0d dz=0",
                 va[i], vb[i], lat, bus_if.q, bus_if.r, bus_if.div_zero, vq[i], vr[i]);
      end
      $display("vector %0d/%0d: lat=%0d q=%0d r=%0d", va[i], vb[i], lat, bus_if.q, bus_if.r);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    launch(4'd8, 4'd0, lat);
    n_cmp++;
    if (lat !== 1 || bus_if.q !== 4'd15 || bus_if.r !== 4'd8 || bus_if.div_zero !== 1'b1 || bus_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL div_zero_8_0: got lat=%0d q=%0d r=%0d dz=%0b busy=%0b, want lat=1 q=15 r=8 dz=1 busy=1",
               lat, bus_if.q, bus_if.r, bus_if.div_zero, bus_if.busy);
    end
    $display("div_zero 8/0: lat=%0d q=%0d r=%0d dz=%0b", lat, bus_if.q, bus_if.r, bus_if.div_zero);
    launch(4'd6, 4'd2, lat);
    n_cmp++;
    if (lat !== 5 || bus_if.q !== 4'd3 || bus_if.r !== 4'd0 || bus_if.div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL div_zero_clear: got lat=%0d q=%0d r=%0d dz=%0b, want lat=5 q=3 r=0 dz=0",
               lat, bus_if.q, bus_if.r, bus_if.div_zero);
    end
    $display("after div_zero 6/2: lat=%0d q=%0d r=%0d dz=%0b", lat, bus_if.q, bus_if.r, bus_if.div_zero);
  endtask

  // Prior result is 6/2 -> q=3, r=0; it must hold until the 13/3 done.
  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.a = 4'd13; bus_if.b = 4'd3;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.a = 4'd2; bus_if.b = 4'd1;
    @(negedge clk);
    bus_if.start = 1'b0;
    n_cmp++;
    if (bus_if.q !== 4'd3 || bus_if.r !== 4'd0 || bus_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_hold_prior: got q=%0d r=%0d done=%0b mid-run, want q=3 r=0 done=0",
               bus_if.q, bus_if.r, bus_if.done);
    end
    lat = 3;
    while (!bus_if.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 5 || bus_if.q !== 4'd4 || bus_if.r !== 4'd1) begin
      n_fail++;
      $display("FAIL ignore_result: got lat=%0d q=%0d r=%0d, want lat=5 q=4 r=1", lat, bus_if.q, bus_if.r);
    end
    @(negedge clk);
    n_cmp++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_no_restart: got busy=%0b done=%0b after done, want 0 0", bus_if.busy, bus_if.done);
    end
    $display("ignore start during run: lat=%0d q=%0d r=%0d", lat, bus_if.q, bus_if.r);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen_done;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.a = 4'd13; bus_if.b = 4'd3;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus_if.busy, bus_if.done, bus_if.q, bus_if.r, bus_if.div_zero} !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_mid_run: got busy=%0b done=%0b q=%0d r=%0d dz=%0b, want all 0",
               bus_if.busy, bus_if.done, bus_if.q, bus_if.r, bus_if.div_zero);
    end
    seen_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus_if.done) seen_done++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.done || bus_if.busy) seen_done++;
    end
    n_cmp++;
    if (seen_done !== 0) begin
      n_fail++;
      $display("FAIL rst_no_done: got %0d done/busy samples after abort, want 0", seen_done);
    end
    launch(4'd9, 4'd2, lat);
    n_cmp++;
    if (lat !== 5 || bus_if.q !== 4'd4 || bus_if.r !== 4'd1 || bus_if.div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_then_9_2: got lat=%0d q=%0d r=%0d dz=%0b, want lat=5 q=4 r=1 dz=0",
               lat, bus_if.q, bus_if.r, bus_if.div_zero);
    end
    $display("reset mid-run then 9/2: lat=%0d q=%0d r=%0d", lat, bus_if.q, bus_if.r);
  endtask

  task automatic test_back_to_back();
    int last_idx;
    int n_done;
    logic prev_done;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.a = 4'd13; bus_if.b = 4'd3;
    last_idx = -1;
    n_done = 0;
    prev_done = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus_if.done) begin
        n_done++;
        n_cmp++;
        if (prev_done) begin
          n_fail++;
          $display("FAIL b2b_width: done high on consecutive cycles at sample %0d, want 1-cycle pulse", i);
        end
        n_cmp++;
        if (last_idx >= 0 && (i - last_idx) !== 6) begin
          n_fail++;
          $display("FAIL b2b_period: got %0d cycles between dones, want 6", i - last_idx);
        end
        n_cmp++;
        if (bus_if.q !== 4'd4 || bus_if.r !== 4'd1) begin
          n_fail++;
          $display("FAIL b2b_result: got q=%0d r=%0d, want q=4 r=1", bus_if.q, bus_if.r);
        end
        $display("back-to-back done at sample %0d: q=%0d r=%0d", i, bus_if.q, bus_if.r);
        last_idx = i;
      end
      prev_done = bus_if.done;
    end
    bus_if.start = 1'b0;
    n_cmp++;
    if (n_done !== 5) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done pulses in 30 cycles, want 5", n_done);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_sweep();
    int lat;
    int bad;
    logic [3:0] eq, er;
    logic edz;
    int el;
    bad = 0;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        if (bi == 0) begin
          eq = 4'd15; er = 4'(ai); edz = 1'b1; el = 1;
        end else begin
          eq = 4'(ai / bi); er = 4'(ai % bi); edz = 1'b0; el = 5;
        end
        launch(4'(ai), 4'(bi), lat);
        n_cmp++;
        if (lat !== el || bus_if.q !== eq || bus_if.r !== er || bus_if.div_zero !== edz) begin
          n_fail++;
          bad++;
          $display("FAIL sweep_%0d_%0d: got lat=%0d q=%0d r=%0d dz=%0b, want lat=%0d q=%0d r=%0d dz=%0b",
                   ai, bi, lat, bus_if.q, bus_if.r, bus_if.div_zero, el, eq, er, edz);
        end
      end
    end
    $display("sweep: 256 pairs, %0d wrong", bad);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
